// File: rtl/spfp_add_sub.sv
// IEEE-754 binary32 adder/subtractor, purely combinational datapath.
// Denormals flush to zero, round-to-nearest-even, one canonical quiet NaN.
module spfp_add_sub (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    input  logic        add_or_sub,
    output logic [31:0] z
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned EXT_W  = SIG_W + 3;   // significand, guard, round, sticky
    localparam int unsigned ALN_W  = SIG_W + 26;  // alignment window
    localparam int unsigned MAG_W  = EXP_W + FRAC_W;
    localparam int unsigned LZ_W   = 5;
    localparam int unsigned XE_W   = 10;          // signed working exponent
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    // clk/rst only exist for ALU port uniformity
    logic w_unused;
    assign w_unused = clk ^ rst;

    logic               w_sa, w_sb;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [FRAC_W-1:0]  w_fa, w_fb;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [MAG_W-1:0]   w_mag_a, w_mag_b;
    logic               w_swap;

    assign w_sa = n1[31];
    assign w_sb = n2[31] ^ ~add_or_sub;
    assign w_ea = n1[30:23];
    assign w_eb = n2[30:23];
    assign w_fa = n1[22:0];
    assign w_fb = n2[22:0];

    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != '0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != '0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == '0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);

    assign w_mag_a = w_a_zero ? '0 : {w_ea, w_fa};
    assign w_mag_b = w_b_zero ? '0 : {w_eb, w_fb};
    assign w_swap  = w_mag_b > w_mag_a;

    // Larger operand (l) and smaller operand (s) after the magnitude swap
    logic              w_sl;
    logic [EXP_W-1:0]  w_el, w_es, w_ediff;
    logic [SIG_W-1:0]  w_ml, w_ms;

    assign w_sl = w_swap ? w_sb : w_sa;
    assign w_el = w_swap ? w_eb : w_ea;
    assign w_es = w_swap ? w_ea : w_eb;
    assign w_ml = w_swap ? (w_b_zero ? '0 : {1'b1, w_fb}) : (w_a_zero ? '0 : {1'b1, w_fa});
    assign w_ms = w_swap ? (w_a_zero ? '0 : {1'b1, w_fa}) : (w_b_zero ? '0 : {1'b1, w_fb});
    assign w_ediff = w_el - w_es;

    logic [ALN_W-1:0] w_aln;
    logic [EXT_W-1:0] w_l_ext, w_s_ext;

    assign w_aln   = {w_ms, {(ALN_W - SIG_W){1'b0}}} >> w_ediff;
    assign w_l_ext = {w_ml, 3'b000};
    assign w_s_ext = (w_ediff >= 8'd26) ? {{(EXT_W - 1){1'b0}}, |w_ms}
                                        : {w_aln[49:24], |w_aln[23:0]};

    logic             w_same;
    logic [EXT_W:0]   w_sum;
    logic [EXT_W-1:0] w_dif;
    logic [LZ_W-1:0]  w_lzc;

    assign w_same = (w_sa == w_sb);
    assign w_sum  = {1'b0, w_l_ext} + {1'b0, w_s_ext};
    assign w_dif  = w_l_ext - w_s_ext;

    // Leading-zero count of the difference; the highest set bit wins
    always_comb begin
        w_lzc = LZ_W'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (w_dif[i]) w_lzc = LZ_W'(EXT_W - 1 - i);
        end
    end

    logic             w_carry;
    logic [LZ_W-1:0]  w_nshift;
    logic [EXT_W-1:0] w_mnorm;

    // Normalize: carry-out shifts right, cancellation shifts left
    always_comb begin
        w_carry  = 1'b0;
        w_nshift = '0;
        w_mnorm  = w_sum[EXT_W-1:0];
        if (w_same) begin
            if (w_sum[EXT_W]) begin
                w_carry = 1'b1;
                w_mnorm = {w_sum[EXT_W:2], |w_sum[1:0]};
            end
        end else begin
            w_nshift = w_lzc;
            w_mnorm  = w_dif << w_lzc;
        end
    end

    logic signed [XE_W-1:0] w_exp_norm, w_exp_fin;
    logic                   w_rnd_up, w_rovf;
    logic [SIG_W:0]         w_rsig;
    logic [FRAC_W-1:0]      w_frac;

    assign w_exp_norm = $signed({2'b00, w_el}) + $signed({9'b0, w_carry})
                      - $signed({5'b0, w_nshift});

    assign w_rnd_up  = w_mnorm[2] & (w_mnorm[1] | w_mnorm[0] | w_mnorm[3]);
    assign w_rsig    = {1'b0, w_mnorm[EXT_W-1:3]} + (SIG_W + 1)'(w_rnd_up);
    assign w_rovf    = w_rsig[SIG_W];
    assign w_frac    = w_rovf ? w_rsig[SIG_W-1:1] : w_rsig[FRAC_W-1:0];
    assign w_exp_fin = w_exp_norm + $signed({9'b0, w_rovf});

    // Result select: specials take priority over the arithmetic path
    always_comb begin
        z = {w_sl, w_exp_fin[EXP_W-1:0], w_frac};
        if (w_a_nan || w_b_nan) begin
            z = QNAN;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            z = QNAN;
        end else if (w_a_inf) begin
            z = {w_sa, 8'hFF, 23'b0};
        end else if (w_b_inf) begin
            z = {w_sb, 8'hFF, 23'b0};
        end else if (w_a_zero && w_b_zero) begin
            z = {w_sa & w_sb, 31'b0};
        end else if (!w_same && (w_dif == '0)) begin
            z = 32'h0000_0000;
        end else if (w_exp_norm <= 10'sd0) begin
            z = {w_sl, 31'b0};
        end else if (w_exp_fin >= 10'sd255) begin
            z = {w_sl, 8'hFF, 23'b0};
        end
    end

endmodule

// File: tb/tb_spfp_add_sub.sv
// Bench for spfp_add_sub: directed corner cases plus randomized vectors
// checked against a double-precision arithmetic reference.
module tb_spfp_add_sub;

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] FULL_MASK = 32'hFFFF_FFFF;
    localparam logic [31:0] GATE_MASK = 32'hFFFF_F800;
    localparam int          N_RAND    = 20000;

    logic        clk;
    logic        rst;
    logic [31:0] n1, n2;
    logic        add_or_sub;
    logic [31:0] z;

    int n_vec;
    int n_miss;

    spfp_add_sub dut (
        .clk        (clk),
        .rst        (rst),
        .n1         (n1),
        .n2         (n2),
        .add_or_sub (add_or_sub),
        .z          (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // binary32 fields -> real, denormals flushed to signed zero
    function automatic real f2r(input logic s, input logic [7:0] e, input logic [22:0] f);
        logic [63:0] d;
        if (e == 8'd0) d = {s, 63'b0};
        else           d = {s, 11'(e) + 11'd896, f, 29'b0};
        return $bitstoreal(d);
    endfunction

    // real -> binary32 with RNE, flush-to-zero below 2^-126, overflow to infinity
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] sg;
        logic        up;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'b0};
        m  = {1'b1, d[51:0]};
        up = m[28] & ((|m[27:0]) | m[29]);
        sg = {1'b0, m[52:29]} + 25'(up);
        if (sg[24]) e = e + 1;
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        return {d[63], 8'(e), sg[22:0]};
    endfunction

    // Sum of two binary32 values is exact enough in double that one final
    // rounding to single gives the correctly rounded result.
    function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b, input logic add);
        logic sb, a_nan, b_nan, a_inf, b_inf;
        real  r;
        sb    = b[31] ^ ~add;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan) return QNAN;
        if (a_inf && b_inf && (a[31] != sb)) return QNAN;
        if (a_inf) return {a[31], 8'hFF, 23'b0};
        if (b_inf) return {sb, 8'hFF, 23'b0};
        if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0)) return {a[31] & sb, 31'b0};
        r = f2r(a[31], a[30:23], a[22:0]) + f2r(sb, b[30:23], b[22:0]);
        if (r == 0.0) return 32'h0000_0000;
        return r2f(r);
    endfunction

    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp, input logic [31:0] mask);
        @(posedge clk);
        n1         = a;
        n2         = b;
        add_or_sub = op;
        #2;
        check_eq(tag, z & mask, exp & mask);
    endtask

    function automatic logic [31:0] pick_special(input int k);
        logic [31:0] tbl [8];
        tbl[0] = 32'h0000_0000; tbl[1] = 32'h8000_0000;
        tbl[2] = 32'h7F80_0000; tbl[3] = 32'hFF80_0000;
        tbl[4] = 32'h7FC0_0001; tbl[5] = 32'h0000_1234;
        tbl[6] = 32'h7F7F_FFFF; tbl[7] = 32'h0080_0000;
        return tbl[k];
    endfunction

    initial begin
        logic [31:0] a, b, exp_z;
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        n1         = '0;
        n2         = '0;
        add_or_sub = 1'b1;

        // Directed cases, first few with rst held high
        apply("3-1",        32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, FULL_MASK);
        apply("1-3",        32'h3F80_0000, 32'h4040_0000, 1'b0, 32'hC000_0000, FULL_MASK);
        rst = 1'b0;
        apply("1+1",        32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, FULL_MASK);
        apply("1.5-1.5",    32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h0000_0000, FULL_MASK);
        apply("cancel23",   32'h3F80_0000, 32'h3F7F_FFFF, 1'b0, 32'h3380_0000, FULL_MASK);
        apply("bigGap",     32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, FULL_MASK);
        apply("ovf",        32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, FULL_MASK);
        apply("inf-inf",    32'h7F80_0000, 32'h7F80_0000, 1'b0, QNAN,          FULL_MASK);
        apply("nanIn",      32'h7FC0_0001, 32'h3F80_0000, 1'b1, QNAN,          FULL_MASK);
        apply("1-inf",      32'h3F80_0000, 32'h7F80_0000, 1'b0, 32'hFF80_0000, FULL_MASK);
        apply("-0+-0",      32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, FULL_MASK);
        apply("+0-(-0)",    32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, FULL_MASK);
        apply("-0-(+0)",    32'h8000_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, FULL_MASK);
        apply("denorm+1",   32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, FULL_MASK);
        apply("underflow",  32'h0080_0001, 32'h0080_0000, 1'b0, 32'h0000_0000, FULL_MASK);
        apply("tieEvenDn",  32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F80_0000, FULL_MASK);
        apply("tieEvenUp",  32'h3F80_0001, 32'h3380_0000, 1'b1, 32'h3F80_0002, FULL_MASK);
        apply("carryRnd",   32'h3FFF_FFFF, 32'h3400_0000, 1'b1, 32'h4000_0000, FULL_MASK);

        // rst toggled with operands held: z must not move
        @(posedge clk); rst = 1'b1; #2;
        check_eq("rstHi", z, 32'h4000_0000);
        @(posedge clk); rst = 1'b0; #2;
        check_eq("rstLo", z, 32'h4000_0000);

        // Randomized regression, subtract pass then add pass
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < N_RAND; i++) begin
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 7))
                    0: b[30:23] = a[30:23];
                    1: b[30:23] = a[30:23] - 8'd1;
                    2: b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
                    3: b = a ^ 32'($urandom_range(0, 255));
                    4: b = pick_special(int'($urandom_range(0, 7)));
                    5: a = pick_special(int'($urandom_range(0, 7)));
                    default: ;
                endcase
                rst = ((i >= 5000) && (i < 5200)) ? ~rst : 1'b0;
                exp_z = ref_fp(a, b, 1'(op));
                apply($sformatf("rnd op=%0d %08h %08h", op, a, b), a, b, 1'(op), exp_z, GATE_MASK);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
